// File: rtl/fetch_unit.sv
// Instruction fetch: holds the PC, reads imem over req/ready, hands words to decode over valid/ack.
// Latency: instr_valid rises on the edge after imem_ready; zero-wait memory plus same-cycle ack gives 2 cycles/instr.
// Backpressure: a stalled memory holds imem_req/imem_addr; a withheld instr_ack holds instr/pc steady indefinitely.
module fetch_unit #(
  parameter logic [31:0] RESET_PC    = 32'h0000_0000,
  parameter logic [5:0]  HALT_OPCODE = 6'h3f
) (
  input  logic        clk,
  input  logic        rst,
  output logic        imem_req,
  output logic [31:0] imem_addr,
  input  logic        imem_ready,
  input  logic [31:0] imem_rdata,
  output logic [31:0] instr,
  output logic        instr_valid,
  input  logic        instr_ack,
  output logic [31:0] pc,
  output logic [31:0] pc_plus4,
  input  logic        branch_taken,
  input  logic [15:0] branch_offset,
  input  logic        jump,
  input  logic [25:0] jump_target,
  output logic        halted
);

  typedef enum logic [1:0] {IDLE, REQ, HOLD, HALT} state_t;

  state_t      state_q;
  state_t      state_d;
  logic [31:0] pc_q;
  logic [31:0] instr_q;
  logic [31:0] next_pc;
  logic        fetch_done;
  logic        fetch_halt;
  logic        instr_accept;

  // The request address is always the PC: it is updated on the ack edge, so
  // the new request and the new PC appear together.
  assign pc         = pc_q;
  assign pc_plus4   = pc_q + 32'd4;
  assign imem_addr  = pc_q;
  assign instr      = instr_q;

  // Handshake qualifiers; ready/ack outside their owning state are ignored.
  assign fetch_done   = (state_q == REQ) && imem_ready;
  assign fetch_halt   = imem_rdata[31:26] == HALT_OPCODE;
  assign instr_accept = (state_q == HOLD) && instr_ack;

  // Next-PC select, only consumed on the ack edge: jump over taken beq over sequential.
  always_comb begin
    next_pc = pc_plus4;
    if (jump) begin
      next_pc = {pc_plus4[31:28], jump_target, 2'b00};
    end else if (branch_taken) begin
      next_pc = pc_plus4 + {{14{branch_offset[15]}}, branch_offset, 2'b00};
    end
  end

  // State register; reset abandons any outstanding request.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  // Next-state and Moore outputs.
  always_comb begin
    state_d     = state_q;
    imem_req    = 1'b0;
    instr_valid = 1'b0;
    halted      = 1'b0;
    case (state_q)
      IDLE: begin
        state_d = REQ;
      end
      REQ: begin
        imem_req = 1'b1;
        if (fetch_done) begin
          state_d = fetch_halt ? HALT : HOLD;
        end
      end
      HOLD: begin
        instr_valid = 1'b1;
        if (instr_accept) begin
          state_d = REQ;
        end
      end
      HALT: begin
        halted = 1'b1;
      end
      default: begin
        state_d = IDLE;
      end
    endcase
  end

  // PC advances only when decode consumes the current instruction.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      pc_q <= RESET_PC;
    end else if (instr_accept) begin
      pc_q <= next_pc;
    end
  end

  // Capture the fetched word; a halt word is never presented to decode.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      instr_q <= 32'h0;
    end else if (fetch_done && !fetch_halt) begin
      instr_q <= imem_rdata;
    end
  end

endmodule

// File: tb/tb_fetch_unit.sv
module tb_fetch_unit;

  logic        clk;
  logic        rst;
  logic        imem_req;
  logic [31:0] imem_addr;
  logic        imem_ready;
  logic [31:0] imem_rdata;
  logic [31:0] instr;
  logic        instr_valid;
  logic        instr_ack;
  logic [31:0] pc;
  logic [31:0] pc_plus4;
  logic        branch_taken;
  logic [15:0] branch_offset;
  logic        jump;
  logic [25:0] jump_target;
  logic        halted;

  int n_checks = 0;
  int n_fail   = 0;

  typedef struct packed {
    logic [31:0] instr;
    logic [31:0] pc;
  } sb_t;
  sb_t sb[$];

  typedef struct {
    logic        j;
    logic [25:0] tgt;
    logic        br;
    logic [15:0] off;
    int          rep;
    int          waits;
    int          ack_wait;
    logic [31:0] exp_addr;
  } vec_t;
  vec_t tbl[15];

  localparam logic [31:0] HALT_WORD = 32'hFC00_0000;

  fetch_unit #(.RESET_PC(32'h0000_0000), .HALT_OPCODE(6'h3f)) dut (
    .clk(clk), .rst(rst),
    .imem_req(imem_req), .imem_addr(imem_addr),
    .imem_ready(imem_ready), .imem_rdata(imem_rdata),
    .instr(instr), .instr_valid(instr_valid), .instr_ack(instr_ack),
    .pc(pc), .pc_plus4(pc_plus4),
    .branch_taken(branch_taken), .branch_offset(branch_offset),
    .jump(jump), .jump_target(jump_target),
    .halted(halted)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic check32(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h, expected %h", name, act, exp);
    end
  endtask

  task automatic check1(input string name, input logic act, input logic exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %b, expected %b", name, act, exp);
    end
  endtask

  // Memory contents: non-halt opcode, word derived from its address.
  function automatic logic [31:0] mem_word(input logic [31:0] a);
    return {6'h08, a[27:2]};
  endfunction

  // Reference next-PC for the repeated table steps.
  function automatic logic [31:0] model_next(input logic [31:0] p, input logic j,
                                             input logic [25:0] tgt, input logic br,
                                             input logic [15:0] off);
    logic [31:0] p4;
    p4 = p + 32'd4;
    if (j) return {p4[31:28], tgt, 2'b00};
    if (br) return p4 + {{14{off[15]}}, off, 2'b00};
    return p4;
  endfunction

  // Asserts rst and checks that all outputs take reset values without a clock edge.
  task automatic assert_reset_checks();
    rst = 1'b1;
    #1;
    check1 ("rst_req",    imem_req,    1'b0);
    check32("rst_addr",   imem_addr,   32'h0);
    check32("rst_instr",  instr,       32'h0);
    check1 ("rst_valid",  instr_valid, 1'b0);
    check1 ("rst_halted", halted,      1'b0);
    check32("rst_pc",     pc,          32'h0);
    check32("rst_pc4",    pc_plus4,    32'h4);
  endtask

  task automatic do_reset();
    imem_ready = 1'b0;
    instr_ack  = 1'b0;
    assert_reset_checks();
    tick();
    tick();
    rst = 1'b0;
  endtask

  // One full fetch of a non-halt word at address a, then ack with the given
  // control inputs. Returns right after the ack edge.
  task automatic do_fetch(input logic [31:0] a, input int waits, input int ack_wait,
                          input logic j, input logic [25:0] tgt,
                          input logic br, input logic [15:0] off);
    int   guard;
    sb_t  exp;
    guard = 0;
    while (!imem_req && guard < 8) begin
      tick();
      guard++;
    end
    if (!imem_req) begin
      check1("req_timeout", imem_req, 1'b1);
      return;
    end
    for (int w = 0; w <= waits; w++) begin
      check1 ("req_held",  imem_req,    1'b1);
      check32("req_addr",  imem_addr,   a);
      check1 ("req_novld", instr_valid, 1'b0);
      if (w == waits) begin
        imem_ready = 1'b1;
        imem_rdata = mem_word(a);
        sb.push_back({mem_word(a), a});
      end
      tick();
    end
    for (int w = 0; w <= ack_wait; w++) begin
      check1("hold_valid", instr_valid, 1'b1);
      check1("hold_noreq", imem_req,    1'b0);
      if (sb.size() == 0) begin
        check1("sb_empty", 1'b0, 1'b1);
      end else begin
        exp = sb[0];
        check32("hold_instr", instr,    exp.instr);
        check32("hold_pc",    pc,       exp.pc);
        check32("hold_pc4",   pc_plus4, exp.pc + 32'd4);
      end
      if (w == ack_wait) begin
        instr_ack     = 1'b1;
        imem_ready    = 1'b0;
        jump          = j;
        jump_target   = tgt;
        branch_taken  = br;
        branch_offset = off;
        if (sb.size() > 0) void'(sb.pop_front());
      end else begin
        // Noise that must be ignored outside REQ / outside the ack cycle.
        instr_ack     = 1'b0;
        imem_ready    = $urandom_range(0, 1) != 0;
        imem_rdata    = HALT_WORD;
        jump          = $urandom_range(0, 1) != 0;
        branch_taken  = $urandom_range(0, 1) != 0;
        jump_target   = 26'($urandom);
        branch_offset = 16'($urandom);
      end
      tick();
    end
    instr_ack     = 1'b0;
    imem_ready    = 1'b0;
    jump          = 1'b0;
    branch_taken  = 1'b0;
    branch_offset = 16'($urandom);
    jump_target   = 26'($urandom);
    check1("ack_vld_drop", instr_valid, 1'b0);
    check1("ack_req_rise", imem_req,    1'b1);
  endtask

  initial begin
    logic [31:0] cur;
    logic [31:0] model;

    //          j     tgt            br    off       rep   wt ack exp_addr
    tbl[0]  = '{1'b0, 26'h0,         1'b0, 16'h0000, 1,    0, 0, 32'h0000_0004};
    tbl[1]  = '{1'b0, 26'h0,         1'b0, 16'h0000, 1,    3, 5, 32'h0000_0008};
    tbl[2]  = '{1'b0, 26'h0,         1'b0, 16'h0000, 1,    0, 0, 32'h0000_000C};
    tbl[3]  = '{1'b0, 26'h0,         1'b0, 16'h0000, 1,    0, 0, 32'h0000_0010};
    tbl[4]  = '{1'b0, 26'h0,         1'b1, 16'hFFFC, 1,    0, 0, 32'h0000_0004};
    tbl[5]  = '{1'b1, 26'h000_0004,  1'b0, 16'h0000, 1,    1, 2, 32'h0000_0010};
    tbl[6]  = '{1'b0, 26'h0,         1'b1, 16'h0003, 1,    0, 0, 32'h0000_0020};
    tbl[7]  = '{1'b1, 26'h000_0040,  1'b1, 16'h0005, 1,    0, 0, 32'h0000_0100};
    tbl[8]  = '{1'b0, 26'h0,         1'b0, 16'h1234, 1,    0, 1, 32'h0000_0104};
    tbl[9]  = '{1'b0, 26'h0,         1'b1, 16'hFFBD, 1,    0, 0, 32'hFFFF_FFFC};
    tbl[10] = '{1'b0, 26'h0,         1'b0, 16'h0000, 1,    2, 0, 32'h0000_0000};
    tbl[11] = '{1'b1, 26'h3FF_FFFF,  1'b0, 16'h0000, 1,    0, 0, 32'h0FFF_FFFC};
    tbl[12] = '{1'b0, 26'h0,         1'b0, 16'h0000, 1,    0, 0, 32'h1000_0000};
    tbl[13] = '{1'b0, 26'h0,         1'b1, 16'h7FFF, 4096, 0, 0, 32'h3000_0000};
    tbl[14] = '{1'b1, 26'h000_0040,  1'b1, 16'hFFFC, 1,    0, 0, 32'h3000_0100};

    rst           = 1'b0;
    imem_ready    = 1'b0;
    imem_rdata    = 32'h0;
    instr_ack     = 1'b0;
    branch_taken  = 1'b0;
    branch_offset = 16'h0;
    jump          = 1'b0;
    jump_target   = 26'h0;
    #2;
    do_reset();

    // Sequential, waits, branches, jump priority, wrap-around.
    cur = 32'h0;
    for (int i = 0; i < 15; i++) begin
      for (int r = 0; r < tbl[i].rep; r++) begin
        do_fetch(cur, tbl[i].waits, tbl[i].ack_wait, tbl[i].j, tbl[i].tgt, tbl[i].br, tbl[i].off);
        model = model_next(cur, tbl[i].j, tbl[i].tgt, tbl[i].br, tbl[i].off);
        if (tbl[i].rep > 1) check32("step_addr", imem_addr, model);
        cur = model;
      end
      check32($sformatf("vec%0d_addr", i), imem_addr, tbl[i].exp_addr);
    end

    // Halt word at 0x8: never presented, fetch stops for good.
    do_reset();
    do_fetch(32'h0, 0, 0, 1'b0, 26'h0, 1'b0, 16'h0);
    do_fetch(32'h4, 0, 0, 1'b0, 26'h0, 1'b0, 16'h0);
    check32("halt_req_addr", imem_addr, 32'h8);
    imem_ready = 1'b1;
    imem_rdata = HALT_WORD;
    tick();
    for (int c = 0; c < 20; c++) begin
      imem_ready = $urandom_range(0, 1) != 0;
      imem_rdata = mem_word(32'h8);
      instr_ack  = $urandom_range(0, 1) != 0;
      check1("halt_flag",  halted,      1'b1);
      check1("halt_noreq", imem_req,    1'b0);
      check1("halt_novld", instr_valid, 1'b0);
      tick();
    end
    check32("halt_instr_kept", instr, mem_word(32'h4));
    do_reset();

    // Reset in the middle of a request, with a late ready that must be ignored.
    do_fetch(32'h0, 0, 0, 1'b0, 26'h0, 1'b0, 16'h0);
    check32("mid_req_addr", imem_addr, 32'h4);
    assert_reset_checks();
    tick();
    imem_ready = 1'b1;
    imem_rdata = HALT_WORD;
    rst        = 1'b0;
    tick();
    imem_ready = 1'b0;
    check1 ("restart_req",    imem_req,    1'b1);
    check32("restart_addr",   imem_addr,   32'h0);
    check1 ("restart_halted", halted,      1'b0);
    check1 ("restart_novld",  instr_valid, 1'b0);
    do_fetch(32'h0, 0, 0, 1'b0, 26'h0, 1'b0, 16'h0);
    check32("restart_next", imem_addr, 32'h4);

    check32("sb_drained", 32'(sb.size()), 32'h0);
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/fetch_unit.md
Name: fetch_unit

Overview:
Instruction fetch stage directly upstream of the instruction decoder/controller. Holds the PC and issues word reads to instruction memory over a req/ready handshake. Presents each fetched word to decode over a valid/ack handshake, and selects the next PC as sequential, beq-taken, or jump. It stops fetching permanently when it fetches a halt word (opcode 6'h3f).

Parameters:
RESET_PC, 32'h0000_0000, PC loaded on reset; must be word aligned (bits [1:0] = 0)
HALT_OPCODE, 6'h3f, opcode in instr[31:26] that stops the fetch unit

Ports:
clk  input  1  single clock; all state updates on rising edge
rst  input  1  asynchronous, active-high reset
imem_req  output  1  read request to instruction memory
imem_addr  output  32  byte address of the request; bits [1:0] always 0
imem_ready  input  1  memory returns imem_rdata this cycle
imem_rdata  input  32  instruction word; valid only when imem_ready=1
instr  output  32  fetched instruction presented to decode
instr_valid  output  1  instr, pc and pc_plus4 are valid
instr_ack  input  1  decode consumes instr this cycle
pc  output  32  address of instr
pc_plus4  output  32  pc + 4 (mod 2^32)
branch_taken  input  1  beq resolved taken for the acked instr
branch_offset  input  16  beq immediate in words, signed
jump  input  1  acked instr is j
jump_target  input  26  j instr_index field
halted  output  1  halt word fetched; fetch stopped

Behaviour:
- Reset (async, immediate): state=IDLE, pc=RESET_PC, imem_req=0, imem_addr=RESET_PC, instr=0, instr_valid=0, halted=0. Any outstanding request is abandoned.
- FSM states are IDLE, REQ, HOLD and HALT.
- IDLE: the first clk edge after rst deasserts moves to REQ. imem_req=1 and imem_addr=pc from that edge.
- REQ: imem_req=1 and imem_addr are held stable until imem_ready=1 is sampled.
  - On the imem_ready edge, if imem_rdata[31:26]==HALT_OPCODE: imem_req=0, halted=1, instr_valid stays 0, go to HALT.
  - Otherwise: instr<=imem_rdata, instr_valid<=1, imem_req<=0, go to HOLD.
- HOLD: instr, pc and pc_plus4 stay stable and instr_valid=1 until instr_ack=1 is sampled.
  - On the ack edge: instr_valid<=0, pc<=next_pc, go to REQ with imem_req=1 and imem_addr=next_pc on the same edge.
- next_pc is evaluated only in the ack cycle; branch and jump inputs are ignored in all other cycles.
  - Priority is jump > branch_taken > sequential.
  - jump: {pc_plus4[31:28], jump_target, 2'b00}
  - branch: pc_plus4 + ({{14{branch_offset[15]}}, branch_offset, 2'b00})
  - sequential: pc_plus4
- All address arithmetic is 32-bit modulo 2^32. Wrap-around at 32'hFFFF_FFFC to 0 is legal.
- HALT: terminal. imem_req=0, instr_valid=0, halted=1. Only rst leaves this state.
- imem_ready while imem_req=0 is ignored, including after a reset mid-request.
- instr_ack while instr_valid=0 is ignored.
- Throughput: zero-wait memory with same-cycle ack gives 2 cycles per instruction (REQ, HOLD).
- Latency: instr_valid rises on the edge after imem_ready is sampled. Each wait cycle on imem_ready or instr_ack adds exactly one cycle.

Test Plan:
1. Reset with RESET_PC=0, zero-wait memory returning add (32'h0000_0020 pattern), ack held high. Required: imem_addr sequence 0,4,8,C; instr_valid pulses every 2nd cycle; pc/pc_plus4 = 0/4, 4/8, and so on.
2. Memory inserts 3 wait cycles on the fetch at 0x4. Required: imem_req and imem_addr=0x4 held stable for 4 cycles; then instr_valid=1. Separately, withhold ack for 5 cycles: instr and pc stay constant throughout.
3. beq at pc=0x10 acked with branch_taken=1, branch_offset=16'hFFFC. Required: next imem_addr=0x04. With offset=16'h0003: next imem_addr=0x20.
4. j at pc=0x3000_0000, jump_target=26'h000_0040, branch_taken=1 in the same ack cycle. Required: next imem_addr=0x3000_0100 (jump wins).
5. Memory returns 32'hFC00_0000 (opcode 3f) at 0x8. Required: halted=1, instr_valid never asserts for it, imem_req=0 for 20 cycles. Then rst returns imem_addr to RESET_PC and halted=0.
6. Assert rst during REQ with imem_ready arriving on the next cycle. Required: all outputs at reset values immediately, the late ready ignored, and fetch restarts at RESET_PC. Separately, sequential fetch from 0xFFFF_FFFC wraps to 0x0.
